// File: rtl/pat_pkg.sv
// Shared types and default widths for the pattern-match scheduler.
package pat_pkg;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/pat_sched_if.sv
// Requester/result bundle for pat_sched.
// PAT_SCHED_MASK_EN adds the pat_mask input.
interface pat_sched_if import pat_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] bit_in;
  logic [N_REQ-1:0] bit_last;
  logic [PAT_W-1:0] pattern;
`ifdef PAT_SCHED_MASK_EN
  logic [PAT_W-1:0] pat_mask;
`endif
  logic [N_REQ-1:0] grant;
  logic             busy;
  logic             done;
  logic [IDW-1:0]   done_id;
  logic [CNT_W-1:0] match_cnt;
  logic             aborted;
  logic             match_pulse;

  modport master (
`ifdef PAT_SCHED_MASK_EN
    output pat_mask,
`endif
    output req, bit_in, bit_last, pattern,
    input  grant, busy, done, done_id, match_cnt, aborted, match_pulse
  );

  modport slave (
`ifdef PAT_SCHED_MASK_EN
    input  pat_mask,
`endif
    input  req, bit_in, bit_last, pattern,
    output grant, busy, done, done_id, match_cnt, aborted, match_pulse
  );
endinterface

// File: rtl/pat_core.sv
// Shift window, received-bit count and masked pattern compare.
module pat_core #(
  parameter int PAT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [PAT_W-1:0] mask,
  output logic             hit
);
  localparam int NW = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] win;
  logic [PAT_W-1:0] win_nxt;
  logic [NW-1:0]    nbits;

  assign win_nxt = {win[PAT_W-2:0], bit_in};
  // the incoming bit counts toward the PAT_W minimum, hence PAT_W-1
  assign hit = en && (nbits >= NW'(PAT_W - 1)) &&
               (((win_nxt ^ pattern) & mask) == '0);

  // shift in sampled bits; count saturates once the window is full
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      win   <= '0;
      nbits <= '0;
    end else if (en) begin
      win <= win_nxt;
      if (nbits != NW'(PAT_W)) nbits <= nbits + 1'b1;
    end
  end
endmodule

// File: rtl/pat_sched.sv
// Round-robin arbiter, frame FSM and match counter around pat_core.
// PAT_SCHED_MASK_EN: latch pat_mask with pattern and compare masked bits only.
module pat_sched import pat_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic       clk,
  input logic       reset,
  pat_sched_if.slave bus
);
  localparam int IDW = $clog2(N_REQ);

  state_t           state;
  logic [N_REQ-1:0] grant_q;
  logic [IDW-1:0]   cur;
  logic [IDW-1:0]   rr_start;
  logic [IDW-1:0]   win_idx;
  logic             any_req;
  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] mask_q;
  logic [CNT_W-1:0] cnt;
  logic             aborted_q;
  logic             pulse_q;
  logic             g_req;
  logic             g_bit;
  logic             g_last;
  logic             sample;
  logic             hit;
  logic             start;
  int               j;

  // round-robin pick: highest-priority index is rr_start, wrapping upward
  always_comb begin
    win_idx = '0;
    any_req = 1'b0;
    j       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(rr_start) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (bus.req[j]) begin
        win_idx = IDW'(j);
        any_req = 1'b1;
      end
    end
  end

  assign g_req  = bus.req[cur];
  assign g_bit  = bus.bit_in[cur];
  assign g_last = bus.bit_last[cur];
  assign sample = (state == STREAM) && g_req;
  assign start  = (state == IDLE) && any_req;

`ifdef PAT_SCHED_MASK_EN
  // mask is frame-constant, captured alongside the pattern
  always_ff @(posedge clk) begin
    if (!reset)     mask_q <= '1;
    else if (start) mask_q <= bus.pat_mask;
  end
`else
  assign mask_q = '1;
`endif

  pat_core #(.PAT_W(PAT_W)) u_core (
    .clk     (clk),
    .reset   (reset),
    .clr     (state == IDLE),
    .en      (sample),
    .bit_in  (g_bit),
    .pattern (pat_q),
    .mask    (mask_q),
    .hit     (hit)
  );

  // frame sequencing, grant, saturating match count and abort flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      grant_q   <= '0;
      cur       <= '0;
      rr_start  <= '0;
      pat_q     <= '0;
      cnt       <= '0;
      aborted_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      pulse_q <= hit;
      case (state)
        IDLE: if (any_req) begin
          state     <= STREAM;
          grant_q   <= N_REQ'(1) << win_idx;
          cur       <= win_idx;
          rr_start  <= (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          pat_q     <= bus.pattern;
          cnt       <= '0;
          aborted_q <= 1'b0;
        end
        STREAM: begin
          if (!g_req) begin
            aborted_q <= 1'b1;
            grant_q   <= '0;
            state     <= REPORT;
          end else begin
            if (hit && !(&cnt)) cnt <= cnt + 1'b1;
            if (g_last) begin
              grant_q <= '0;
              state   <= REPORT;
            end
          end
        end
        REPORT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == REPORT);
  assign bus.done_id     = cur;
  assign bus.match_cnt   = cnt;
  assign bus.aborted     = aborted_q;
  assign bus.match_pulse = pulse_q;
endmodule

// File: tb/tb_pat_sched.sv
// Directed bench for pat_sched; a second instance with CNT_W=2 shares the stimulus.
module tb_pat_sched;
  localparam int N = 4;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pat_sched_if #(.N_REQ(N), .PAT_W(PW), .CNT_W(8)) ifc ();
  pat_sched_if #(.N_REQ(N), .PAT_W(PW), .CNT_W(2)) ifc2 ();

  assign ifc2.req      = ifc.req;
  assign ifc2.bit_in   = ifc.bit_in;
  assign ifc2.bit_last = ifc.bit_last;
  assign ifc2.pattern  = ifc.pattern;
`ifdef PAT_SCHED_MASK_EN
  assign ifc2.pat_mask = ifc.pat_mask;
`endif

  pat_sched #(.N_REQ(N), .PAT_W(PW), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(ifc.slave));
  pat_sched #(.N_REQ(N), .PAT_W(PW), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(ifc2.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one frame from requester id, MSB of data first; abort_at drops req at that bit
  task automatic frame(input string nm, input int id, input logic [31:0] data,
                       input int len, input int abort_at, input logic [PW-1:0] pat,
                       input int exp_cnt, input int exp_cnt2, input logic exp_ab);
    int w;
    int pulses;
    logic b;
    ifc.pattern = pat;
    ifc.req[id] = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (ifc.grant == '0 && w < 20);
    chk({nm, ".lat"}, w, 1);
    chk({nm, ".grant"}, {28'd0, ifc.grant}, 32'd1 << id);
    ifc.pattern = ~pat;
    pulses = 0;
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) begin
        ifc.req[id] = 1'b0;
      end else begin
        b = data[len-1-i];
        ifc.bit_in = b ? 4'b0000 : 4'b1111;
        ifc.bit_in[id] = b;
        ifc.bit_last = 4'b1111;
        ifc.bit_last[id] = (i == len - 1);
      end
      @(negedge clk);
      pulses += int'(ifc.match_pulse);
      if (i == abort_at) break;
    end
    chk({nm, ".done"}, ifc.done, 1);
    chk({nm, ".id"}, ifc.done_id, id);
    chk({nm, ".cnt"}, ifc.match_cnt, exp_cnt);
    chk({nm, ".cnt2"}, ifc2.match_cnt, exp_cnt2);
    chk({nm, ".abort"}, ifc.aborted, exp_ab);
    chk({nm, ".pulses"}, pulses, exp_cnt);
    chk({nm, ".rptgnt"}, ifc.grant, 0);
    ifc.req[id]  = 1'b0;
    ifc.bit_in   = '0;
    ifc.bit_last = '0;
    ifc.pattern  = pat;
    @(negedge clk);
    chk({nm, ".done1"}, ifc.done, 0);
    chk({nm, ".idle"}, ifc.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b0;
    ifc.req      = '0;
    ifc.bit_in   = '0;
    ifc.bit_last = '0;
    ifc.pattern  = '0;
`ifdef PAT_SCHED_MASK_EN
    ifc.pat_mask = '1;
`endif
    repeat (2) @(negedge clk);
    chk("rst.grant", ifc.grant, 0);
    chk("rst.busy", ifc.busy, 0);
    chk("rst.done", ifc.done, 0);
    chk("rst.id", ifc.done_id, 0);
    chk("rst.cnt", ifc.match_cnt, 0);
    chk("rst.abort", ifc.aborted, 0);
    chk("rst.pulse", ifc.match_pulse, 0);
    reset = 1'b1;
    @(negedge clk);

    frame("b7",   0, 32'h00B7,  16, -1, 8'hB7, 1, 1, 1'b0);
    frame("ones", 0, 32'h0FFF,  12, -1, 8'hFF, 5, 3, 1'b0);
    frame("short",1, 32'h0007,   3, -1, 8'hFF, 0, 0, 1'b0);
    // last served is 1: with 1,2,3 pending the order is 2,3,1
    ifc.req[1] = 1'b1; ifc.req[2] = 1'b1; ifc.req[3] = 1'b1;
    frame("rr2",  2, 32'h00FF,   8, -1, 8'hFF, 1, 1, 1'b0);
    frame("rr3",  3, 32'h01FF,   9, -1, 8'hFF, 2, 2, 1'b0);
    frame("rr1",  1, 32'h007F,   8, -1, 8'hFF, 0, 0, 1'b0);
    frame("abort",2, 32'h03FF,  10,  5, 8'hFF, 0, 0, 1'b1);
    frame("sat",  0, 32'hFFFFF, 20, -1, 8'hFF, 13, 3, 1'b0);

    // reset in the middle of a frame from requester 1
    ifc.pattern = 8'hFF;
    ifc.req[1]  = 1'b1;
    @(negedge clk);
    chk("mr.grant", ifc.grant, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      ifc.bit_in[1] = 1'b1;
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("mr.grant0", ifc.grant, 0);
    chk("mr.busy0", ifc.busy, 0);
    chk("mr.done0", ifc.done, 0);
    reset        = 1'b1;
    ifc.req      = '0;
    ifc.bit_in   = '0;
    @(negedge clk);
    chk("mr.done1", ifc.done, 0);
    chk("mr.busy1", ifc.busy, 0);
    // pointer would favour 2 without reset; after reset 0 is searched first
    ifc.req[2] = 1'b1;
    frame("post", 0, 32'h00B7, 8, -1, 8'hB7, 1, 1, 1'b0);
    ifc.req[2] = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/pat_sched.md
PAT_SCHED -- requirements
Module: pat_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the matcher, 2..8.
REQ-002 Parameter PAT_W, default 8: pattern length in bits, 2..16.
REQ-003 Parameter CNT_W, default 8: match-counter width.
REQ-004 clk  in  1  single clock, all logic on posedge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 req  in  N_REQ  per-requester frame request, held high until its frame is done.
REQ-007 bit_in  in  N_REQ  per-requester serial data bit, valid every cycle the requester is granted.
REQ-008 bit_last  in  N_REQ  marks the final bit of a frame.
REQ-009 pattern  in  PAT_W  match pattern, MSB is the oldest bit, sampled at frame start.
REQ-010 grant  out  N_REQ  one-hot grant, zero when idle.
REQ-011 busy  out  1  a frame is in progress.
REQ-012 done  out  1  one-cycle frame-complete pulse.
REQ-013 done_id  out  clog2(N_REQ)  index of the completed requester, valid with done.
REQ-014 match_cnt  out  CNT_W  matches in the completed frame, valid with done.
REQ-015 aborted  out  1  completed frame was cut short by req dropping, valid with done.
REQ-016 match_pulse  out  1  one-cycle pulse in the cycle after a matching bit is sampled.

Function
REQ-017 The FSM SHALL have states IDLE, STREAM and REPORT.
REQ-018 IDLE: if any req is high, the next state SHALL be STREAM with grant set to the winner; otherwise stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: search starts at the index one above the last served requester and wraps from N_REQ-1 to 0; after reset, search starts at index 0.
REQ-020 On entering STREAM, the shift window and the bit count SHALL be cleared, and pattern SHALL be latched.
REQ-021 STREAM: each cycle SHALL sample the granted bit_in into the window LSB.
REQ-022 A match SHALL be the window equal to the latched pattern with at least PAT_W bits received in this frame; overlapping matches SHALL each count.
REQ-023 match_cnt SHALL saturate at all-ones.
REQ-024 When bit_last of the granted requester is sampled, the next state SHALL be REPORT, and that bit SHALL be included in matching.
REQ-025 If the granted req is low in a STREAM cycle, the bit SHALL NOT be sampled, aborted SHALL be set, and the next state SHALL be REPORT.
REQ-026 REPORT: done=1 for exactly one cycle with done_id, match_cnt and aborted.
REQ-027 In REPORT, grant SHALL be zero; the next state SHALL be IDLE, so the earliest regrant is two cycles after the last bit.
REQ-028 busy SHALL be high in STREAM and REPORT.
REQ-029 Frames shorter than PAT_W bits SHALL report match_cnt=0.
REQ-030 Changes on req, bit_in or pattern of non-granted requesters SHALL have no effect.

Reset
REQ-031 On reset low at a clock edge:
- state=IDLE
- grant=0, busy=0, done=0, done_id=0, match_cnt=0, aborted=0, match_pulse=0
- round-robin pointer set so that index 0 is searched first
REQ-032 Reset mid-frame SHALL discard the frame without a done pulse.

Configuration
REQ-033 With macro PAT_SCHED_MASK_EN defined, an extra input pat_mask (PAT_W bits) SHALL be latched together with pattern, and only the bits set in the mask SHALL be compared.
REQ-034 Without PAT_SCHED_MASK_EN, the port SHALL be absent and all PAT_W bits SHALL be compared.

Structure
REQ-035 A shared package pat_pkg SHALL hold the FSM state enum (IDLE, STREAM, REPORT) and the default widths PAT_W and CNT_W.
REQ-036 The window, bit count and compare logic SHALL be a sub-module pat_core (inputs: clr, en, bit, pattern; output: hit).
REQ-037 pat_sched SHALL hold the arbiter, the FSM and the counter.

Verification
REQ-038 Pattern 8'b10110111; requester 0 sends 16 bits 0x00B7 with bit_last on bit 16. Required: grant=0001 one cycle after req, done_id=0, match_cnt=1, aborted=0.
REQ-039 Pattern 8'b11111111; 12 ones. Required: match_cnt=5 (overlap), one match_pulse per match.
REQ-040 req[1], req[2] and req[3] all high, last served requester 1. Required grant order 2, 3, 1, each done separated by an IDLE cycle.
REQ-041 Requester 2 drops req after 5 bits. Required: done with done_id=2, aborted=1, match_cnt=0.
REQ-042 CNT_W=2, pattern all ones, 20 ones. Required: match_cnt=3 (saturated).
REQ-043 Reset pulled low mid-STREAM. Required: next cycle grant=0, busy=0, no done pulse; the next frame is served from index 0.
